// File: rtl/ram_1r1w_rr_arbiter.sv
// ram_1r1w_rr_arbiter: round-robin sharing of one 1R1W RAM among REQUESTERS masters.
// Define RAM_ARB_RAW_BYPASS_EN to forward same-cycle write data to a colliding read.
module ram_1r1w_rr_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int BBITS      = (DBITS + 7) / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQUESTERS-1:0]       req_i,
  input  logic [REQUESTERS-1:0]       we_i,
  input  logic [REQUESTERS*ABITS-1:0] addr_i,
  input  logic [REQUESTERS*DBITS-1:0] wdata_i,
  input  logic [REQUESTERS*BBITS-1:0] be_i,
  output logic [REQUESTERS-1:0]       gnt_o,
  output logic [REQUESTERS-1:0]       rvalid_o,
  output logic [DBITS-1:0]            rdata_o,
  output logic [ABITS-1:0]            ram_waddr_o,
  output logic [DBITS-1:0]            ram_din_o,
  output logic                        ram_we_o,
  output logic [BBITS-1:0]            ram_be_o,
  output logic [ABITS-1:0]            ram_raddr_o,
  input  logic [DBITS-1:0]            ram_dout_i
);
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [PW-1:0]         wr_ptr, rd_ptr, w_idx, r_idx;
  logic                  w_found, r_found;
  logic [REQUESTERS-1:0] w_oh, r_oh, rvalid_q;
  logic [ABITS-1:0]      raddr_q;

  // First candidate after ptr (wrapping) wins; the index defaults to ptr when none.
  function automatic logic [PW:0] rr_pick(input logic [REQUESTERS-1:0] cand, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int k;
    res = {1'b0, ptr};
    for (int i = 1; i <= REQUESTERS; i++) begin
      k = (int'(ptr) + i) % REQUESTERS;
      if (!res[PW] && cand[k]) res = {1'b1, PW'(k)};
    end
    return res;
  endfunction

  assign {w_found, w_idx} = rr_pick(req_i & we_i, wr_ptr);
  assign {r_found, r_idx} = rr_pick(req_i & ~we_i, rd_ptr);

  assign w_oh  = w_found ? REQUESTERS'(1) << w_idx : '0;
  assign r_oh  = r_found ? REQUESTERS'(1) << r_idx : '0;
  assign gnt_o = rst_i ? '0 : w_oh | r_oh;

  assign ram_we_o    = w_found & ~rst_i;
  assign ram_waddr_o = addr_i[w_idx*ABITS +: ABITS];
  assign ram_din_o   = wdata_i[w_idx*DBITS +: DBITS];
  assign ram_be_o    = be_i[w_idx*BBITS +: BBITS];
  assign ram_raddr_o = r_found ? addr_i[r_idx*ABITS +: ABITS] : raddr_q;
  assign rvalid_o    = rvalid_q;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_ptr   <= PW'(REQUESTERS - 1);
      rd_ptr   <= PW'(REQUESTERS - 1);
      rvalid_q <= '0;
      raddr_q  <= '0;
    end else begin
      if (w_found) wr_ptr <= w_idx;
      if (r_found) rd_ptr <= r_idx;
      if (r_found) raddr_q <= ram_raddr_o;
      rvalid_q <= r_oh;
    end

`ifdef RAM_ARB_RAW_BYPASS_EN
  logic             raw_hit;
  logic [DBITS-1:0] din_q, mask;
  logic [BBITS-1:0] be_q;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      raw_hit <= 1'b0;
      din_q   <= '0;
      be_q    <= '0;
    end else begin
      raw_hit <= w_found & r_found & (ram_waddr_o == ram_raddr_o);
      din_q   <= ram_din_o;
      be_q    <= ram_be_o;
    end

  always_comb begin
    mask = '0;
    for (int b = 0; b < DBITS; b++) mask[b] = raw_hit & be_q[b/8];
  end

  assign rdata_o = (mask & din_q) | (~mask & ram_dout_i);
`else
  assign rdata_o = ram_dout_i;
`endif
endmodule

// File: tb/tb_ram_1r1w_rr_arbiter.sv
// tb_ram_1r1w_rr_arbiter: vector table plus read-data scoreboard for the RAM arbiter.
module tb_ram_1r1w_rr_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [1:0]  req, we, gnt, rvalid;
  logic [19:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [9:0]  ram_waddr, ram_raddr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [3:0]  req4, gnt4, rvalid4, ram_be4;
  logic [31:0] rdata4, ram_din4;
  logic [9:0]  ram_waddr4, ram_raddr4;
  logic        ram_we4;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int tests = 0, fails = 0;

  typedef struct {
    logic [1:0] req, we;
    logic [9:0] a0, a1;
    logic [31:0] d0, d1;
    logic [3:0] b0, b1;
    logic [1:0] gnt;
    logic wen;
  } vec_t;
  typedef struct { logic [1:0] rv; logic [31:0] data; } exp_t;
  exp_t q[$];
  vec_t tbl[16];

  always #5 clk_i = ~clk_i;

  ram_1r1w_rr_arbiter #(.REQUESTERS(2), .ABITS(10), .DBITS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .ram_waddr_o(ram_waddr), .ram_din_o(ram_din),
    .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_raddr_o(ram_raddr), .ram_dout_i(ram_dout));

  ram_1r1w_rr_arbiter #(.REQUESTERS(4), .ABITS(10), .DBITS(32)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req4), .we_i(4'b0000), .addr_i(40'h0), .wdata_i(128'h0), .be_i(16'h0),
    .gnt_o(gnt4), .rvalid_o(rvalid4), .rdata_o(rdata4), .ram_waddr_o(ram_waddr4), .ram_din_o(ram_din4),
    .ram_we_o(ram_we4), .ram_be_o(ram_be4), .ram_raddr_o(ram_raddr4), .ram_dout_i(32'h0));

  // Registered-read RAM without bypass; cleared while reset is held across an edge.
  always @(posedge clk_i) begin
    if (rst_i) for (int i = 0; i < 1024; i++) mem[i] <= '0;
    else if (ram_we) for (int b = 0; b < 4; b++) if (ram_be[b]) mem[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [1:0] req_v, logic [1:0] we_v, logic [9:0] a0, logic [31:0] d0, logic [3:0] b0,
                              logic [9:0] a1, logic [31:0] d1, logic [3:0] b1, logic [1:0] g, logic wen);
    vec_t v;
    v.req = req_v; v.we = we_v; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.gnt = g; v.wen = wen;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] bm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (bm[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check_cycle(input vec_t v);
    logic [9:0] a[2];
    logic [31:0] d[2];
    logic [3:0] bm[2];
    exp_t e, n;
    a[0] = v.a0; a[1] = v.a1; d[0] = v.d0; d[1] = v.d1; bm[0] = v.b0; bm[1] = v.b1;
    req = v.req; we = v.we; addr = {v.a1, v.a0}; wdata = {v.d1, v.d0}; be = {v.b1, v.b0};
    @(negedge clk_i);
    e.rv = 2'b00; e.data = '0;
    if (q.size() > 0) e = q.pop_front();
    chk("rvalid", 32'(rvalid), 32'(e.rv));
    if (e.rv != 2'b00) chk("rdata", rdata, e.data);
    chk("gnt", 32'(gnt), 32'(v.gnt));
    chk("ram_we", 32'(ram_we), 32'(v.wen));
    n.rv = 2'b00; n.data = '0;
    for (int m = 0; m < 2; m++)
      if (v.gnt[m] && !v.we[m]) begin
        n.rv[m] = 1'b1;
        n.data = ref_mem[a[m]];
`ifdef RAM_ARB_RAW_BYPASS_EN
        for (int w = 0; w < 2; w++)
          if (v.gnt[w] && v.we[w] && a[w] == a[m]) n.data = merge(n.data, d[w], bm[w]);
`endif
      end
    for (int m = 0; m < 2; m++)
      if (v.gnt[m] && v.we[m]) ref_mem[a[m]] = merge(ref_mem[a[m]], d[m], bm[m]);
    q.push_back(n);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    req = 2'b11; we = 2'b11; addr = '0; wdata = '0; be = '0; req4 = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    tbl[0]  = mk(2'b11, 2'b11, 10'h100, 32'hA0A0A0A0, 4'hF, 10'h101, 32'hA1A1A1A1, 4'hF, 2'b01, 1'b1);
    tbl[1]  = tbl[0]; tbl[1].gnt = 2'b10;
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[1];
    tbl[4]  = mk(2'b10, 2'b10, 10'h000, 32'h0, 4'h0, 10'h010, 32'h12345678, 4'hF, 2'b10, 1'b1);
    tbl[5]  = mk(2'b11, 2'b01, 10'h03C, 32'hDEADBEEF, 4'hF, 10'h010, 32'h0, 4'h0, 2'b11, 1'b1);
    tbl[6]  = mk(2'b01, 2'b01, 10'h005, 32'hAABBCCDD, 4'b0101, 10'h000, 32'h0, 4'h0, 2'b01, 1'b1);
    tbl[7]  = mk(2'b01, 2'b00, 10'h005, 32'h0, 4'h0, 10'h000, 32'h0, 4'h0, 2'b01, 1'b0);
    tbl[8]  = mk(2'b11, 2'b01, 10'h020, 32'hCAFEF00D, 4'hF, 10'h020, 32'h0, 4'h0, 2'b11, 1'b1);
    tbl[9]  = mk(2'b10, 2'b10, 10'h000, 32'h0, 4'h0, 10'h03C, 32'h11111111, 4'h0, 2'b10, 1'b1);
    tbl[10] = mk(2'b01, 2'b00, 10'h03C, 32'h0, 4'h0, 10'h000, 32'h0, 4'h0, 2'b01, 1'b0);
    tbl[11] = mk(2'b00, 2'b00, 10'h000, 32'h0, 4'h0, 10'h000, 32'h0, 4'h0, 2'b00, 1'b0);
    tbl[12] = mk(2'b11, 2'b00, 10'h100, 32'h0, 4'h0, 10'h101, 32'h0, 4'h0, 2'b10, 1'b0);
    tbl[13] = mk(2'b11, 2'b00, 10'h100, 32'h0, 4'h0, 10'h101, 32'h0, 4'h0, 2'b01, 1'b0);
    tbl[14] = mk(2'b10, 2'b00, 10'h000, 32'h0, 4'h0, 10'h010, 32'h0, 4'h0, 2'b10, 1'b0);
    tbl[15] = tbl[14];
    for (int i = 0; i < 16; i++) begin
      check_cycle(tbl[i]);
      @(posedge clk_i); #1;
    end

    // Read granted, then reset held across the next edge: the pending rvalid must vanish.
    check_cycle(mk(2'b10, 2'b00, 10'h000, 32'h0, 4'h0, 10'h010, 32'h0, 4'h0, 2'b10, 1'b0));
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    q.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    check_cycle(mk(2'b11, 2'b00, 10'h010, 32'h0, 4'h0, 10'h010, 32'h0, 4'h0, 2'b01, 1'b0));
    @(posedge clk_i); #1;
    check_cycle(mk(2'b10, 2'b00, 10'h000, 32'h0, 4'h0, 10'h010, 32'h0, 4'h0, 2'b10, 1'b0));
    @(posedge clk_i); #1;
    check_cycle(mk(2'b00, 2'b00, 10'h000, 32'h0, 4'h0, 10'h000, 32'h0, 4'h0, 2'b00, 1'b0));
    @(posedge clk_i); #1;

    begin
      int cnt[4];
      logic [3:0] exp_g;
      for (int m = 0; m < 4; m++) cnt[m] = 0;
      req4 = 4'hF;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk_i);
        exp_g = 4'b0001 << (c % 4);
        chk("fair_gnt", 32'(gnt4), 32'(exp_g));
        for (int m = 0; m < 4; m++) if (gnt4[m]) cnt[m]++;
        @(posedge clk_i); #1;
      end
      req4 = '0;
      for (int m = 0; m < 4; m++) chk("fair_count", cnt[m], 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
